dmem_arbiter: RTL

- Two-requester arbiter and sequencer in front of the single-ported 64-word data memory (combinational read, write on posedge clk).
- Requester C is the pipeline MEM stage; requester D is the debug/DMA loader port.
- CPU has fixed priority, but a starvation counter guarantees D forward progress.
- Read data is registered and returned one cycle after grant, together with a per-requester valid pulse.

---
 rtl/mips_mem_pkg.sv | 12 +
 rtl/dmem_starve_ctr.sv | 29 ++
 rtl/dmem_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared widths and response-owner encoding for the data-memory arbiter slice.
package mips_mem_pkg;
  localparam int DW       = 32;
  localparam int AW       = 32;
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_C    = 2'd1,
    RESP_D    = 2'd2
  } resp_owner_t;
endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating wait counter for the debug port; raises force_d once D has waited
// STARVE_MAX consecutive CPU wins.
module dmem_starve_ctr
  import mips_mem_pkg::STARVE_W;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                inc,
  output logic [STARVE_W-1:0] cnt,
  output logic                force_d
);
  localparam logic [STARVE_W-1:0] MAX_V = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0] SAT_V = {STARVE_W{1'b1}};

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != SAT_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_d = (cnt >= MAX_V);
endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-ported data memory: CPU (C) has
// priority, debug/DMA (D) is guaranteed progress; loads return one cycle later.
//
// resp_owner | meaning
// NONE       | no load response this cycle
// C          | c_rdata holds last cycle's CPU load, c_rvalid high
// D          | d_rdata holds last cycle's debug load, d_rvalid high
module dmem_arbiter
  import mips_mem_pkg::resp_owner_t;
  import mips_mem_pkg::RESP_NONE;
  import mips_mem_pkg::RESP_C;
  import mips_mem_pkg::RESP_D;
  import mips_mem_pkg::STARVE_W;
#(
  parameter int DW         = mips_mem_pkg::DW,
  parameter int AW         = mips_mem_pkg::AW,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                c_req,
  input  logic                c_we,
  input  logic [AW-1:0]       c_addr,
  input  logic [DW-1:0]       c_wdata,
  output logic                c_gnt,
  output logic                c_rvalid,
  output logic [DW-1:0]       c_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [AW-1:0]       d_addr,
  input  logic [DW-1:0]       d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DW-1:0]       d_rdata,
  output logic                mem_we,
  output logic [AW-1:0]       mem_a,
  output logic [DW-1:0]       mem_wd,
  input  logic [DW-1:0]       mem_rd,
  output logic [STARVE_W-1:0] starve_cnt
);
  logic        force_d;
  resp_owner_t owner_q;
  resp_owner_t owner_d;

  // Grants are suppressed during reset so no store can slip through.
  assign d_gnt = ~reset & d_req & (~c_req | force_d);
  assign c_gnt = ~reset & c_req & ~d_gnt;

  dmem_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .clr     (d_gnt | ~d_req),
    .inc     (d_req & c_gnt),
    .cnt     (starve_cnt),
    .force_d (force_d)
  );

  // Misaligned stores still take their grant but never reach the memory.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (d_gnt) begin
      mem_we = d_we & (d_addr[1:0] == 2'b00);
      mem_a  = d_addr;
      mem_wd = d_wdata;
    end else if (c_gnt) begin
      mem_we = c_we & (c_addr[1:0] == 2'b00);
      mem_a  = c_addr;
      mem_wd = c_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= RESP_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    owner_d = RESP_NONE;
    if (c_gnt && !c_we) begin
      owner_d = RESP_C;
    end else if (d_gnt && !d_we) begin
      owner_d = RESP_D;
    end
  end

  always_comb begin
    c_rvalid = (owner_q == RESP_C);
    d_rvalid = (owner_q == RESP_D);
  end

  // Only the owner of the load captures; the other requester's data holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (owner_d == RESP_C) c_rdata <= mem_rd;
      if (owner_d == RESP_D) d_rdata <= mem_rd;
    end
  end
endmodule
